// File: rtl/seq_slice_comparator.sv
// seq_slice_comparator
//
// Multi-cycle magnitude comparator. Two WIDTH-bit operands are captured on a
// start request and compared SLICE bits per clock, most significant slice
// first, so no WIDTH-bit compare path is needed in a single cycle. Supports
// unsigned and two's-complement compares. The result is published as
// registered one-hot lt/gt/eq flags together with a one-cycle done pulse.
//
// Optional build macro: CMP_EARLY_EXIT_EN
//   defined   -> the first differing slice finishes the compare on that edge
//   undefined -> fixed latency of NSLICE RUN edges
//
// Ports:
//   clk         in   rising-edge clock
//   rst         in   synchronous active-high reset
//   start       in   compare request, sampled only while idle
//   in_a        in   operand A (WIDTH bits), captured on the accepting edge
//   in_b        in   operand B (WIDTH bits), captured on the accepting edge
//   signed_mode in   1 = two's-complement compare, 0 = unsigned
//   busy        out  high while a compare is in progress
//   done        out  one-cycle pulse when the flags are updated
//   out_lt      out  registered A < B
//   out_gt      out  registered A > B
//   out_eq      out  registered A == B
module seq_slice_comparator #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             signed_mode,
    output logic             busy,
    output logic             done,
    output logic             out_lt,
    output logic             out_gt,
    output logic             out_eq
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

    if ((WIDTH % SLICE) != 0) begin : g_bad_slice
        $error("seq_slice_comparator: SLICE must divide WIDTH exactly");
    end

    typedef enum logic {S_IDLE, S_RUN} state_t;
    typedef enum logic [1:0] {DEC_UND, DEC_LT, DEC_GT} dec_t;

    state_t           r_state, w_state_nxt;
    dec_t             r_dec, w_dec_nxt, w_dec_upd;
    logic [IDXW-1:0]  r_idx, w_idx_nxt;
    logic [WIDTH-1:0] r_a, r_b, w_a_nxt, w_b_nxt;
    logic             r_sgn, w_sgn_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_done, w_done_nxt;
    logic             r_lt, r_gt, r_eq, w_lt_nxt, w_gt_nxt, w_eq_nxt;

    logic [31:0]      w_lsb;
    logic [WIDTH-1:0] w_a_sh, w_b_sh;
    logic [SLICE-1:0] w_sa, w_sb;
    logic             w_flip;
    logic             w_finish;

    // Select the current slice by shifting it down to bit 0.
    assign w_lsb  = 32'(r_idx) * SLICE;
    assign w_a_sh = r_a >> w_lsb;
    assign w_b_sh = r_b >> w_lsb;

    // In signed mode the top slice is compared with the sign bits inverted,
    // which maps two's-complement order onto unsigned order.
    assign w_flip = r_sgn && (r_idx == LAST_IDX);

    always_comb begin
        w_sa = w_a_sh[SLICE-1:0];
        w_sb = w_b_sh[SLICE-1:0];
        w_sa[SLICE-1] = w_sa[SLICE-1] ^ w_flip;
        w_sb[SLICE-1] = w_sb[SLICE-1] ^ w_flip;
    end

    // A decision, once made by a more significant slice, is never overwritten.
    always_comb begin
        w_dec_upd = r_dec;
        if (r_dec == DEC_UND) begin
            if (w_sa < w_sb) begin
                w_dec_upd = DEC_LT;
            end else if (w_sa > w_sb) begin
                w_dec_upd = DEC_GT;
            end
        end
    end

`ifdef CMP_EARLY_EXIT_EN
    assign w_finish = (r_idx == '0) || (w_dec_upd != DEC_UND);
`else
    assign w_finish = (r_idx == '0);
`endif

    // Next-state and output logic
    always_comb begin
        w_state_nxt = r_state;
        w_dec_nxt   = r_dec;
        w_idx_nxt   = r_idx;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_sgn_nxt   = r_sgn;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_lt_nxt    = r_lt;
        w_gt_nxt    = r_gt;
        w_eq_nxt    = r_eq;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_a_nxt     = in_a;
                    w_b_nxt     = in_b;
                    w_sgn_nxt   = signed_mode;
                    w_idx_nxt   = LAST_IDX;
                    w_dec_nxt   = DEC_UND;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_dec_nxt = w_dec_upd;
                w_idx_nxt = r_idx - IDXW'(1);
                if (w_finish) begin
                    w_state_nxt = S_IDLE;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_lt_nxt    = (w_dec_upd == DEC_LT);
                    w_gt_nxt    = (w_dec_upd == DEC_GT);
                    w_eq_nxt    = (w_dec_upd == DEC_UND);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // Control and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_dec   <= DEC_UND;
            r_idx   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_lt    <= 1'b0;
            r_gt    <= 1'b0;
            r_eq    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_dec   <= w_dec_nxt;
            r_idx   <= w_idx_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_lt    <= w_lt_nxt;
            r_gt    <= w_gt_nxt;
            r_eq    <= w_eq_nxt;
        end
    end

    // Operand latches carry data only and need no reset.
    always_ff @(posedge clk) begin
        r_a   <= w_a_nxt;
        r_b   <= w_b_nxt;
        r_sgn <= w_sgn_nxt;
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign out_lt = r_lt;
    assign out_gt = r_gt;
    assign out_eq = r_eq;

endmodule

// File: tb/tb_seq_slice_comparator.sv
module tb_seq_slice_comparator;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        signed_mode;
    logic        busy;
    logic        done;
    logic        out_lt;
    logic        out_gt;
    logic        out_eq;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seq_slice_comparator #(
        .WIDTH(16),
        .SLICE(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_a       (in_a),
        .in_b       (in_b),
        .signed_mode(signed_mode),
        .busy       (busy),
        .done       (done),
        .out_lt     (out_lt),
        .out_gt     (out_gt),
        .out_eq     (out_eq)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sm;
        logic [2:0]  flags;     // {lt, gt, eq}
        int          lat_base;
        int          lat_ee;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_lat(input vec_t v);
`ifdef CMP_EARLY_EXIT_EN
        return v.lat_ee;
`else
        return v.lat_base;
`endif
    endfunction

    task automatic run_vec(input vec_t v, input int i);
        int n;
        int busy_cnt;
        start       = 1'b1;
        in_a        = v.a;
        in_b        = v.b;
        signed_mode = v.sm;
        step();                          // edge 0: accept
        start       = 1'b0;
        in_a        = ~v.a;              // operands may change after capture
        in_b        = 16'($urandom);
        signed_mode = ~v.sm;
        busy_cnt    = busy ? 1 : 0;
        n           = 0;
        while (n < 20 && !done) begin
            step();
            n++;
            if (!done && busy) busy_cnt++;
        end
        chk($sformatf("v%0d_latency", i), n, exp_lat(v));
        chk($sformatf("v%0d_flags", i), {out_lt, out_gt, out_eq}, v.flags);
        chk($sformatf("v%0d_busy_cycles", i), busy_cnt, exp_lat(v));
        chk($sformatf("v%0d_busy_low_at_done", i), busy, 0);
        step();
        chk($sformatf("v%0d_done_single", i), done, 0);
        chk($sformatf("v%0d_flags_hold", i), {out_lt, out_gt, out_eq}, v.flags);
    endtask

    initial begin
        int e;
        int done_seen;
        int hold_bad;

        //            a         b         sm    {lt,gt,eq} base ee
        vecs[0]  = '{16'hC3C3, 16'hC3C3, 1'b0, 3'b001, 4, 4};
        vecs[1]  = '{16'h4000, 16'hC000, 1'b0, 3'b100, 4, 1};
        vecs[2]  = '{16'h4000, 16'hC000, 1'b1, 3'b010, 4, 1};
        vecs[3]  = '{16'hFFFF, 16'h0000, 1'b1, 3'b100, 4, 1};
        vecs[4]  = '{16'h1235, 16'h1234, 1'b0, 3'b010, 4, 4};
        vecs[5]  = '{16'h8000, 16'h0001, 1'b0, 3'b010, 4, 1};
        vecs[6]  = '{16'h1234, 16'h1234, 1'b1, 3'b001, 4, 4};
        vecs[7]  = '{16'h0010, 16'h0020, 1'b1, 3'b100, 4, 3};
        vecs[8]  = '{16'h8000, 16'h7FFF, 1'b1, 3'b100, 4, 1};
        vecs[9]  = '{16'hABCD, 16'hABCE, 1'b0, 3'b100, 4, 4};
        vecs[10] = '{16'h0F00, 16'h0E00, 1'b1, 3'b010, 4, 2};

        rst         = 1'b1;
        start       = 1'b0;
        in_a        = 16'h0;
        in_b        = 16'h0;
        signed_mode = 1'b0;
        step();
        step();
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_flags", {out_lt, out_gt, out_eq}, 3'b000);
        rst = 1'b0;
        step();
        chk("idle_flags_before_first", {out_lt, out_gt, out_eq}, 3'b000);
        chk("idle_done", done, 0);

        for (int i = 0; i < 11; i++) begin
            run_vec(vecs[i], i);
        end

        // start while busy is ignored
        in_a = 16'h0001; in_b = 16'h0002; signed_mode = 1'b0; start = 1'b1;
        step();                          // edge 0
        start = 1'b0;
        step();                          // edge 1
        start = 1'b1; in_a = 16'h0000; in_b = 16'h0000;
        step();                          // edge 2: ignored
        start = 1'b0;
        e = 2;
        while (e < 20 && !done) begin
            step();
            e++;
        end
        chk("ign_latency", e, 4);
        chk("ign_flags", {out_lt, out_gt, out_eq}, 3'b100);
        step();
        chk("ign_no_restart", busy, 0);

        // reset aborts a compare mid-run
        in_a = 16'h0005; in_b = 16'h0003; start = 1'b1;
        step();                          // edge 0
        start = 1'b0;
        step();
        step();                          // edge 2
        chk("abort_busy_before", busy, 1);
        rst = 1'b1;
        step();                          // edge 3: reset
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_flags", {out_lt, out_gt, out_eq}, 3'b000);
        done_seen = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (done) done_seen++;
        end
        chk("abort_no_done", done_seen, 0);

        // back-to-back: start held through the done cycle
        in_a = 16'h0003; in_b = 16'h0001; signed_mode = 1'b0; start = 1'b1;
        step();                          // edge 0
        in_a = 16'h0002; in_b = 16'h0009;
        e = 0;
        while (e < 20 && !done) begin
            step();
            e++;
        end
        chk("b2b_first_latency", e, 4);
        chk("b2b_first_flags", {out_lt, out_gt, out_eq}, 3'b010);
        step();                          // edge 5: second accepted
        e++;
        start = 1'b0;
        chk("b2b_second_accepted", busy, 1);
        hold_bad = 0;
        while (e < 30 && !done) begin
            if ({out_lt, out_gt, out_eq} != 3'b010) hold_bad++;
            step();
            e++;
        end
        chk("b2b_flags_held", hold_bad, 0);
        chk("b2b_second_latency", e, 9);
        chk("b2b_second_flags", {out_lt, out_gt, out_eq}, 3'b100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
